pipe_mmio_ctrl: RTL and testbench

PIPE_MMIO_CTRL -- requirements
Module: pipe_mmio_ctrl

---
 rtl/rv_pkg.sv | 18 +
 rtl/mmio_region_decode.sv | 27 ++
 rtl/pipe_mmio_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_mmio_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared types and constants for the MMIO pipeline controller.
package rv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [1:0] STRB_BYTE = 2'b00;
    localparam logic [1:0] STRB_HALF = 2'b01;
    localparam logic [1:0] STRB_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        ERR   = 3'd4
    } ctrlState_t;

endpackage

// File: rtl/mmio_region_decode.sv
// Maps the top address nibble to a peripheral channel; lowest matching index wins.
module mmio_region_decode
    import rv_pkg::*;
#(
    parameter int                    NUM_CH  = 2,
    parameter logic [NUM_CH*4-1:0]   CH_BASE = {4'h3, 4'h2},
    parameter int                    IDXW    = 1
) (
    input  logic            valid,
    input  logic [3:0]      nibble,
    output logic            hit,
    output logic [IDXW-1:0] idx
);

    // Scan high-to-low so the lowest matching channel is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (valid && (CH_BASE[i*4 +: 4] == nibble)) begin
                hit = 1'b1;
                idx = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/pipe_mmio_ctrl.sv
// W-stage MMIO controller: stalls the pipeline while a load/store is carried
// out on one peripheral channel, then returns read data or a timeout error.
module pipe_mmio_ctrl
    import rv_pkg::*;
#(
    parameter int                  XLEN    = XLEN_DEF,
    parameter int                  NUM_CH  = 2,
    parameter logic [NUM_CH*4-1:0] CH_BASE = {4'h3, 4'h2},
    parameter int                  TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic                   req_write,
    input  logic [XLEN-1:0]        req_addr,
    input  logic [XLEN-1:0]        req_wdata,
    input  logic [1:0]             req_strobe,
    input  logic [4:0]             req_rd,
    output logic [NUM_CH-1:0]      ch_sel,
    output logic                   ch_wr_en,
    output logic [XLEN-1:0]        ch_addr,
    output logic [XLEN-1:0]        ch_wdata,
    output logic [1:0]             ch_strobe,
    input  logic [NUM_CH-1:0]      ch_done,
    input  logic [NUM_CH*XLEN-1:0] ch_rdata,
    output logic                   stall,
    output logic                   rd_valid,
    output logic [4:0]             rd_idx,
    output logic [XLEN-1:0]        rd_data,
    output logic                   err
);

    localparam int             IDXW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int             CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TMO  = CW'(TIMEOUT);

    ctrlState_t      state;
    logic [CW-1:0]   waitCnt;
    logic            capWrite;
    logic [4:0]      capRd;
    logic [IDXW-1:0] capIdx;

    logic            hit;
    logic [IDXW-1:0] hitIdx;
    logic            chDone;
    logic [XLEN-1:0] chData;
    logic            respValid;
    logic            timedOut;

    mmio_region_decode #(
        .NUM_CH  (NUM_CH),
        .CH_BASE (CH_BASE),
        .IDXW    (IDXW)
    ) uDecode (
        .valid  (req_valid),
        .nibble (req_addr[XLEN-1 -: 4]),
        .hit    (hit),
        .idx    (hitIdx)
    );

    assign chDone    = ch_done[capIdx];
    assign chData    = ch_rdata[capIdx*XLEN +: XLEN];
    // Writes and reads targeting x0 still handshake but never write back.
    assign respValid = !capWrite && (capRd != 5'd0);
    // Counter value is the number of WAIT cycles already spent.
    assign timedOut  = (waitCnt + 1'b1) == TMO;

    // Combinational so the pipeline freezes in the same cycle the hit is seen.
    assign stall = !rst && (((state == IDLE) && hit) || (state == ISSUE) || (state == WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            waitCnt   <= '0;
            capWrite  <= 1'b0;
            capRd     <= '0;
            capIdx    <= '0;
            ch_sel    <= '0;
            ch_wr_en  <= 1'b0;
            ch_addr   <= '0;
            ch_wdata  <= '0;
            ch_strobe <= '0;
            rd_valid  <= 1'b0;
            rd_idx    <= '0;
            rd_data   <= '0;
            err       <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            rd_idx   <= '0;
            rd_data  <= '0;
            err      <= 1'b0;
            ch_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    waitCnt <= '0;
                    if (hit) begin
                        capWrite  <= req_write;
                        capRd     <= req_rd;
                        capIdx    <= hitIdx;
                        ch_sel    <= NUM_CH'(1) << hitIdx;
                        ch_wr_en  <= req_write;
                        ch_addr   <= req_addr;
                        ch_wdata  <= req_wdata;
                        ch_strobe <= req_strobe;
                        state     <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    if (chDone) begin
                        ch_sel    <= '0;
                        ch_addr   <= '0;
                        ch_wdata  <= '0;
                        ch_strobe <= '0;
                        rd_valid  <= respValid;
                        rd_idx    <= respValid ? capRd : 5'd0;
                        rd_data   <= respValid ? chData : '0;
                        state     <= RESP;
                    end else if ((state == WAIT) && timedOut) begin
                        ch_sel    <= '0;
                        ch_addr   <= '0;
                        ch_wdata  <= '0;
                        ch_strobe <= '0;
                        err       <= 1'b1;
                        rd_valid  <= respValid;
                        rd_idx    <= respValid ? capRd : 5'd0;
                        waitCnt   <= waitCnt + 1'b1;
                        state     <= ERR;
                    end else begin
                        if (state == WAIT)
                            waitCnt <= waitCnt + 1'b1;
                        state <= WAIT;
                    end
                end
                RESP, ERR: begin
                    waitCnt <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_mmio_ctrl.sv
// Scoreboard bench: the driver predicts channel issues and write-back results
// from the address map, a monitor pops and compares as the DUT presents them.
module tb_pipe_mmio_ctrl;

    localparam int          XLEN   = 32;
    localparam int          NUM_CH = 3;
    localparam int          TMO    = 8;
    localparam logic [11:0] BASES  = 12'h232;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   req_valid, req_write;
    logic [XLEN-1:0]        req_addr, req_wdata;
    logic [1:0]             req_strobe;
    logic [4:0]             req_rd;
    logic [NUM_CH-1:0]      ch_sel;
    logic                   ch_wr_en;
    logic [XLEN-1:0]        ch_addr, ch_wdata;
    logic [1:0]             ch_strobe;
    logic [NUM_CH-1:0]      ch_done;
    logic [NUM_CH*XLEN-1:0] ch_rdata;
    logic                   stall, rd_valid, err;
    logic [4:0]             rd_idx;
    logic [XLEN-1:0]        rd_data;

    always #5 clk = ~clk;

    pipe_mmio_ctrl #(
        .XLEN(XLEN), .NUM_CH(NUM_CH), .CH_BASE(BASES), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strobe(req_strobe), .req_rd(req_rd),
        .ch_sel(ch_sel), .ch_wr_en(ch_wr_en), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_strobe(ch_strobe),
        .ch_done(ch_done), .ch_rdata(ch_rdata),
        .stall(stall), .rd_valid(rd_valid), .rd_idx(rd_idx),
        .rd_data(rd_data), .err(err)
    );

    typedef struct {
        logic [NUM_CH-1:0] sel;
        logic              wr;
        logic [31:0]       addr;
        logic [31:0]       wdata;
        logic [1:0]        strb;
    } issue_t;

    typedef struct {
        logic        vld;
        logic [4:0]  idx;
        logic [31:0] data;
        logic        err;
    } resp_t;

    issue_t issueQ[$];
    resp_t  respQ[$];
    int     nCmp = 0;
    int     nBad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Address map as a plain table: lowest channel whose region matches.
    function automatic int refIdx(input logic [31:0] addr);
        int bases[NUM_CH] = '{2, 3, 2};
        for (int i = 0; i < NUM_CH; i++)
            if (bases[i] == int'(addr[31:28])) return i;
        return -1;
    endfunction

    logic [NUM_CH-1:0] prevSel  = '0;
    logic [31:0]       prevAddr = '0;

    always @(negedge clk) begin
        issue_t ie;
        resp_t  re;
        if (ch_sel != '0 && prevSel == '0) begin
            if (issueQ.size() == 0) begin
                nCmp++; nBad++;
                $display("FAIL issue: unexpected ch_sel %0h, expected none", ch_sel);
            end else begin
                ie = issueQ.pop_front();
                chk("ch_sel", 64'(ch_sel), 64'(ie.sel));
                chk("ch_wr_en", 64'(ch_wr_en), 64'(ie.wr));
                chk("ch_addr", 64'(ch_addr), 64'(ie.addr));
                chk("ch_wdata", 64'(ch_wdata), 64'(ie.wdata));
                chk("ch_strobe", 64'(ch_strobe), 64'(ie.strb));
            end
        end else begin
            if (ch_wr_en) chk("ch_wr_en_late", 64'(ch_wr_en), 64'd0);
            if (ch_sel != '0) begin
                chk("ch_sel_hold", 64'(ch_sel), 64'(prevSel));
                chk("ch_addr_hold", 64'(ch_addr), 64'(prevAddr));
            end else begin
                chk("ch_idle_bus", {ch_addr, ch_wdata}, 64'd0);
            end
        end
        if (rd_valid || err) begin
            if (respQ.size() == 0) begin
                nCmp++; nBad++;
                $display("FAIL resp: unexpected rd_valid=%0b err=%0b, expected none", rd_valid, err);
            end else begin
                re = respQ.pop_front();
                chk("rd_valid", 64'(rd_valid), 64'(re.vld));
                chk("rd_idx", 64'(rd_idx), 64'(re.idx));
                chk("rd_data", 64'(rd_data), 64'(re.data));
                chk("err", 64'(err), 64'(re.err));
            end
        end
        prevSel  = ch_sel;
        prevAddr = ch_addr;
    end

    // d = cycles after ISSUE at which the channel answers (-1: never).
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] strb, input logic [4:0] rd, input int d,
                       input bit spur, input bit doRst);
        int     idx;
        int     k = 0;
        int     stallCnt = 0;
        int     expStall;
        bit     expV;
        issue_t ie;
        resp_t  re;
        idx  = refIdx(addr);
        expV = !wr && (rd != 5'd0);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr;
        req_wdata = wdata; req_strobe = strb; req_rd = rd;
        if (idx >= 0) begin
            ie.sel = NUM_CH'(1) << idx; ie.wr = wr; ie.addr = addr;
            ie.wdata = wdata; ie.strb = strb;
            issueQ.push_back(ie);
            if (d < 0 && !doRst) begin
                re.vld = expV; re.idx = expV ? rd : 5'd0; re.data = '0; re.err = 1'b1;
                respQ.push_back(re);
            end
        end
        #1;
        if (stall) stallCnt++;
        if (idx < 0) chk("stall_miss", 64'(stall), 64'd0);
        while (idx >= 0 && stall) begin
            @(negedge clk);
            k++;
            ch_rdata = {$urandom, $urandom, $urandom};
            ch_done  = '0;
            if (d >= 0 && k == 1 + d) begin
                ch_done[idx] = 1'b1;
                if (expV) begin
                    re.vld = 1'b1; re.idx = rd; re.data = ch_rdata[idx*32 +: 32]; re.err = 1'b0;
                    respQ.push_back(re);
                end
            end
            if (spur && k == 2) ch_done[(idx + 1) % NUM_CH] = 1'b1;
            if (doRst && k == 3) begin
                rst = 1'b1;
                req_valid = 1'b0;
            end
            #1;
            if (stall) stallCnt++;
            if (doRst && k == 3) chk("stall_in_rst", 64'(stall), 64'd0);
            if (k > 40) begin
                nCmp++; nBad++;
                $display("FAIL stall_stuck: still stalled after %0d cycles, expected release", k);
                break;
            end
        end
        expStall = (idx < 0) ? 0 : doRst ? 3 : (d < 0) ? 2 + TMO : 2 + d;
        chk("stall_cycles", 64'(stallCnt), 64'(expStall));
        if (idx >= 0 && !doRst) begin
            chk("resp_rd_valid_now", 64'(rd_valid), 64'(expV));
            chk("resp_err_now", 64'(err), 64'(d < 0));
        end
        @(negedge clk);
        ch_done   = '0;
        rst       = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_strobe = '0; req_rd = '0; ch_done = '0; ch_rdata = '0;
        repeat (3) @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h2000_0000;
        #1;
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_ch_sel", 64'(ch_sel), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b0;

        txn(1'b0, 32'h2000_0010, 32'h0, 2'b10, 5'd5, 3, 1'b0, 1'b0);
        txn(1'b1, 32'h3000_0004, 32'hA5, 2'b00, 5'd0, 1, 1'b0, 1'b0);
        txn(1'b0, 32'h2000_0100, 32'h0, 2'b10, 5'd7, -1, 1'b0, 1'b0);
        txn(1'b0, 32'h1000_0000, 32'h0, 2'b10, 5'd9, 0, 1'b0, 1'b0);
        txn(1'b0, 32'h2000_0020, 32'h0, 2'b10, 5'd3, -1, 1'b0, 1'b1);
        txn(1'b0, 32'h2000_0024, 32'h0, 2'b01, 5'd6, 2, 1'b0, 1'b0);
        txn(1'b0, 32'h3000_0030, 32'h0, 2'b10, 5'd4, 3, 1'b1, 1'b0);
        txn(1'b0, 32'h2000_0000, 32'h0, 2'b10, 5'd0, 0, 1'b0, 1'b0);
        txn(1'b0, 32'h3000_0008, 32'h0, 2'b10, 5'd1, 0, 1'b0, 1'b0);
        txn(1'b1, 32'h3000_0040, 32'h1234_5678, 2'b10, 5'd0, -1, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic [3:0]  nib;
            logic [31:0] a;
            int          dd;
            bit          sp;
            if ($urandom_range(0, 4) == 0) begin
                int t = $urandom_range(4, 17);
                nib = 4'(t % 16);
            end else begin
                nib = ($urandom_range(0, 1) == 0) ? 4'h2 : 4'h3;
            end
            a  = {nib, 28'($urandom)};
            dd = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
            sp = (dd >= 3) && ($urandom_range(0, 1) == 1);
            txn(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 2)),
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), dd, sp, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("issueQ_drained", 64'(issueQ.size()), 64'd0);
        chk("respQ_drained", 64'(respQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
